junction_phase_scheduler: RTL and testbench
===========================================

# junction_phase_scheduler

Demand-actuated phase scheduler for the 3-way traffic junction. It latches vehicle-detector requests for three conflicting approach phases and serves them round-robin. It sequences each phase through GREEN, AMBER and ALL-RED with tick-based minimum and maximum green times, and drives registered red/amber/green lamp vectors, one bit per phase. It sits between the detector inputs and the junction lamp drivers, replacing fixed-time sequencing.

## Interface
Parameters:
- TICK_DIV, 4: clk cycles per timing tick (≥1)
- GREEN_MIN, 3: minimum green, ticks (≥1)
- GREEN_MAX, 6: maximum green under conflicting demand, ticks (≥GREEN_MIN)
- AMBER_T, 2: amber duration, ticks (≥1)
- ALLRED_T, 1: all-red clearance, ticks (≥1)

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- det  in  3  vehicle detectors, bit i = phase i; synchronous to clk, level-sensitive
- red  out  3  red lamp per phase
- amber  out  3  amber lamp per phase
- green  out  3  green lamp per phase
- phase  out  2  phase currently owning the junction (0..2)
- pend  out  3  latched pending requests

## Operation
- States: ALLRED, GREEN, AMBER. Register cur (0..2) is the owning phase.
- Reset state: ALLRED, cur=2, pend=000.
- Prescaler counts 0..TICK_DIV-1. It restarts at 0 on every state transition. tick=1 when count==TICK_DIV-1. Each state therefore lasts an exact multiple of TICK_DIV cycles.
- Elapsed-tick counter: cleared on state entry, incremented on tick. Width is $clog2(GREEN_MAX+1); it saturates and never wraps.
- pend[i] is set on any cycle with det[i]=1. It is cleared on the edge where GREEN for phase i is entered; clear wins over a same-cycle set. While phase i is green, det[i] does not set pend[i].
- ALLRED → GREEN on the tick where elapsed reaches ALLRED_T. Next phase is the first pending phase in order cur+1, cur+2, cur (mod 3). If none is pending, the next phase is cur+1; after reset this gives phase 0.
- GREEN → AMBER on a tick where all three hold:
  - elapsed ≥ GREEN_MIN after the increment
  - some pend[j] with j≠cur is set
  - det[cur]=0, or elapsed ≥ GREEN_MAX
- Without conflicting demand, green rests indefinitely. The elapsed counter saturates.
- AMBER → ALLRED on the tick where elapsed reaches AMBER_T.
- Lamps, set for the state held:
  - GREEN: green=onehot(cur), red = ~onehot(cur)
  - AMBER: amber=onehot(cur), red = ~onehot(cur)
  - ALLRED: red=111
- Exactly one lamp is lit per phase at all times. At most one phase is non-red.

## Timing
- All outputs are registered. They reflect the state after the clock edge where the transition occurred, so lamp latency is 0 cycles after the state register updates.
- Reset values: red=111, amber=000, green=000, phase=2, pend=000. Outputs go to these values asynchronously on rstn falling. The first release edge starts ALLRED timing with prescaler=0.
- Durations: ALLRED = ALLRED_T·TICK_DIV cycles, AMBER = AMBER_T·TICK_DIV cycles. GREEN lasts GREEN_MIN·TICK_DIV to GREEN_MAX·TICK_DIV cycles under demand.
- pend updates one edge after det is sampled.
- A det pulse of a single cycle is sufficient.
- Reset mid-operation: immediate return to reset values. Pending requests are lost.

## Test plan
All scenarios use defaults (TICK_DIV=4, GREEN_MIN=3, GREEN_MAX=6, AMBER_T=2, ALLRED_T=1).
1. Release rstn with det=000 → red=111 for 4 cycles, then green=001, red=110, phase=0; green stays for 200 cycles.
2. During phase-0 green (cycle 2), pulse det[1] for 1 cycle with det[0]=0 → pend=010; green=001 for 12 cycles total, amber=001 for 8, red=111 for 4, then green=010 and pend=000.
3. Hold det[0]=1 and pulse det[2] at green entry → phase-0 green held 24 cycles (GREEN_MAX), then amber, then green=100.
4. Phase 1 green; pulse det[0] and det[2] in the same cycle → served order is phase 2 then phase 0, each separated by 8 amber + 4 all-red cycles.
5. det[1] asserted on the exact edge phase 1 enters green → pend[1] ends 0. Lamp invariant holds every cycle: one lamp per phase, at most one non-red.
6. Assert rstn=0 mid-amber → red=111, amber=000, pend=000 immediately. After release, the scenario 1 timing repeats.

Source files
------------

// File: rtl/junction_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : junction_phase_scheduler
// Purpose  : Demand-actuated phase scheduler for a 3-way junction. It latches
//            detector requests for three conflicting approach phases, serves
//            them round-robin, and sequences each phase through GREEN, AMBER
//            and ALL-RED. Timing is counted in prescaled ticks. GREEN has a
//            minimum and a maximum duration when other phases are waiting.
// Ports    : clk    - system clock
//            rstn   - asynchronous active-low reset
//            det    - vehicle detectors, bit i = phase i (level, clk-synchronous)
//            red    - registered red lamp per phase
//            amber  - registered amber lamp per phase
//            green  - registered green lamp per phase
//            phase  - phase currently owning the junction (0..2)
//            pend   - latched pending requests
// Revision : 1.0 - initial release
// ============================================================================
module junction_phase_scheduler #(
   parameter int TICK_DIV  = 4,
   parameter int GREEN_MIN = 3,
   parameter int GREEN_MAX = 6,
   parameter int AMBER_T   = 2,
   parameter int ALLRED_T  = 1
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [2:0] det,
   output logic [2:0] red,
   output logic [2:0] amber,
   output logic [2:0] green,
   output logic [1:0] phase,
   output logic [2:0] pend
);

   localparam int c_PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int c_EL_W  = $clog2(GREEN_MAX + 1);

   localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(TICK_DIV - 1);
   localparam logic [c_EL_W-1:0]  c_EL_SAT   = '1;

   typedef enum logic [1:0] {
      S_ALLRED = 2'd0,
      S_GREEN  = 2'd1,
      S_AMBER  = 2'd2
   } state_t;

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   state_t               r_state;
   logic [1:0]           r_cur;
   logic [c_PRE_W-1:0]   r_pre;
   logic [c_EL_W-1:0]    r_elapsed;
   logic [2:0]           r_pend;
   logic [2:0]           r_red;
   logic [2:0]           r_amber;
   logic [2:0]           r_green;

   // -------------------------------------------------------------------------
   // Combinational signals
   // -------------------------------------------------------------------------
   state_t               w_state_nxt;
   logic [1:0]           w_cur_nxt;
   logic                 w_tick;
   logic                 w_trans;
   logic [c_EL_W-1:0]    w_el_inc;
   logic [31:0]          w_el_ext;
   logic                 w_conflict;
   logic [1:0]           w_c1;
   logic [1:0]           w_c2;
   logic [1:0]           w_pick;
   logic                 w_enter_green;
   logic                 w_green_now;
   logic [2:0]           w_pend_nxt;
   logic [2:0]           w_oh_nxt;
   logic [2:0]           w_red_nxt;
   logic [2:0]           w_amber_nxt;
   logic [2:0]           w_green_nxt;

   function automatic logic [2:0] f_onehot(input logic [1:0] p);
      f_onehot = 3'b001 << p;
   endfunction

   // Modulo-3 increment of a phase number
   function automatic logic [1:0] f_next3(input logic [1:0] p);
      f_next3 = (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // -------------------------------------------------------------------------
   // Tick, elapsed-tick and demand evaluation
   // -------------------------------------------------------------------------
   always_comb begin
      w_tick      = (r_pre == c_PRE_LAST);
      // Saturating increment: a resting green must never wrap back below
      // GREEN_MIN and restart its minimum-green window.
      w_el_inc    = (r_elapsed == c_EL_SAT) ? r_elapsed : r_elapsed + c_EL_W'(1);
      w_el_ext    = 32'(w_el_inc);
      w_conflict  = |(r_pend & ~f_onehot(r_cur));
      w_green_now = (r_state == S_GREEN);

      // Round-robin search order cur+1, cur+2, cur. With nothing pending the
      // junction still advances to cur+1, so reset (cur=2) starts at phase 0.
      w_c1 = f_next3(r_cur);
      w_c2 = f_next3(w_c1);
      if (r_pend[w_c1]) begin
         w_pick = w_c1;
      end else if (r_pend[w_c2]) begin
         w_pick = w_c2;
      end else if (r_pend[r_cur]) begin
         w_pick = r_cur;
      end else begin
         w_pick = w_c1;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt   = r_state;
      w_cur_nxt     = r_cur;
      w_enter_green = 1'b0;

      case (r_state)
         S_ALLRED: begin
            if (w_tick && (w_el_ext >= 32'(ALLRED_T))) begin
               w_state_nxt   = S_GREEN;
               w_cur_nxt     = w_pick;
               w_enter_green = 1'b1;
            end
         end
         S_GREEN: begin
            // A still-occupied approach keeps its green until GREEN_MAX,
            // a vacated one yields as soon as GREEN_MIN has elapsed.
            if (w_tick && w_conflict &&
                (w_el_ext >= 32'(GREEN_MIN)) &&
                (!det[r_cur] || (w_el_ext >= 32'(GREEN_MAX)))) begin
               w_state_nxt = S_AMBER;
            end
         end
         S_AMBER: begin
            if (w_tick && (w_el_ext >= 32'(AMBER_T))) begin
               w_state_nxt = S_ALLRED;
            end
         end
         default: begin
            w_state_nxt = S_ALLRED;
         end
      endcase

      w_trans = (w_state_nxt != r_state);
   end

   // -------------------------------------------------------------------------
   // Request latch: the phase being granted green loses its request on the
   // grant edge even if its detector is active on that same edge, and a
   // phase that is already green cannot re-request itself.
   // -------------------------------------------------------------------------
   always_comb begin
      w_pend_nxt = r_pend;
      for (int i = 0; i < 3; i++) begin
         w_pend_nxt[i] = r_pend[i] |
                         (det[i] & ~(w_green_now & (r_cur == 2'(i))));
         if (w_enter_green && (w_cur_nxt == 2'(i))) begin
            w_pend_nxt[i] = 1'b0;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Lamp decode from the next state so the registered lamps change on the
   // same edge as the state register.
   // -------------------------------------------------------------------------
   always_comb begin
      w_oh_nxt    = f_onehot(w_cur_nxt);
      w_red_nxt   = 3'b111;
      w_amber_nxt = 3'b000;
      w_green_nxt = 3'b000;
      case (w_state_nxt)
         S_GREEN: begin
            w_green_nxt = w_oh_nxt;
            w_red_nxt   = ~w_oh_nxt;
         end
         S_AMBER: begin
            w_amber_nxt = w_oh_nxt;
            w_red_nxt   = ~w_oh_nxt;
         end
         default: begin
            w_red_nxt   = 3'b111;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State, timing and output registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= S_ALLRED;
         r_cur     <= 2'd2;
         r_pre     <= '0;
         r_elapsed <= '0;
         r_pend    <= 3'b000;
         r_red     <= 3'b111;
         r_amber   <= 3'b000;
         r_green   <= 3'b000;
      end else begin
         r_state <= w_state_nxt;
         r_cur   <= w_cur_nxt;

         // Prescaler restarts on every transition so each state lasts an
         // exact multiple of TICK_DIV cycles.
         if (w_trans || w_tick) begin
            r_pre <= '0;
         end else begin
            r_pre <= r_pre + c_PRE_W'(1);
         end

         if (w_trans) begin
            r_elapsed <= '0;
         end else if (w_tick) begin
            r_elapsed <= w_el_inc;
         end

         r_pend  <= w_pend_nxt;
         r_red   <= w_red_nxt;
         r_amber <= w_amber_nxt;
         r_green <= w_green_nxt;
      end
   end

   assign red   = r_red;
   assign amber = r_amber;
   assign green = r_green;
   assign phase = r_cur;
   assign pend  = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_junction_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_junction_phase_scheduler
// Purpose  : Directed self-checking bench for junction_phase_scheduler with
//            default parameters. Stimulus is applied and outputs are sampled
//            on the falling clock edge; every expected value is hand-derived.
// Revision : 1.0 - initial release
// ============================================================================
module tb_junction_phase_scheduler;

   logic       clk  = 1'b0;
   logic       rstn = 1'b1;
   logic [2:0] det  = 3'b000;
   logic [2:0] red;
   logic [2:0] amber;
   logic [2:0] green;
   logic [1:0] phase;
   logic [2:0] pend;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;
   logic inv_bad = 1'b0;

   junction_phase_scheduler #(
      .TICK_DIV  (4),
      .GREEN_MIN (3),
      .GREEN_MAX (6),
      .AMBER_T   (2),
      .ALLRED_T  (1)
   ) dut (
      .clk   (clk),
      .rstn  (rstn),
      .det   (det),
      .red   (red),
      .amber (amber),
      .green (green),
      .phase (phase),
      .pend  (pend)
   );

   always #5 clk = ~clk;

   // Lamp invariant: one lamp per phase, at most one phase not red.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if ((32'(red[i]) + 32'(amber[i]) + 32'(green[i])) != 32'd1) inv_bad <= 1'b1;
      end
      if ((32'(!red[0]) + 32'(!red[1]) + 32'(!red[2])) > 32'd1) inv_bad <= 1'b1;
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Compares the packed observation {red, amber, green, phase, pend}.
   task automatic chk(input string tag, input logic [2:0] er, input logic [2:0] ea,
                      input logic [2:0] eg, input logic [1:0] ep, input logic [2:0] epd);
      logic [13:0] obs;
      logic [13:0] exp;
      obs = {red, amber, green, phase, pend};
      exp = {er, ea, eg, ep, epd};
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed r/a/g/ph/pend=%b/%b/%b/%0d/%b expected %b/%b/%b/%0d/%b",
                tag, obs[13:11], obs[10:8], obs[7:5], obs[4:3], obs[2:0],
                er, ea, eg, ep, epd);
      end
   endtask

   initial begin
      // ---- reset ----
      #2 rstn = 1'b0;
      #1 chk("reset_async", 3'b111, 3'b000, 3'b000, 2'd2, 3'b000);
      step(3);
      chk("reset_hold", 3'b111, 3'b000, 3'b000, 2'd2, 3'b000);

      // ---- 1: no demand, first green is phase 0 and rests ----
      rstn = 1'b1;
      step(3);
      chk("s1_allred_end", 3'b111, 3'b000, 3'b000, 2'd2, 3'b000);
      step(1);
      chk("s1_green0", 3'b110, 3'b000, 3'b001, 2'd0, 3'b000);
      step(200);
      chk("s1_rest", 3'b110, 3'b000, 3'b001, 2'd0, 3'b000);

      rstn = 1'b0;
      #1 chk("s1_reset", 3'b111, 3'b000, 3'b000, 2'd2, 3'b000);
      step(2);
      rstn = 1'b1;
      step(4);                                     // G: phase 0 green entry
      chk("s2_green0", 3'b110, 3'b000, 3'b001, 2'd0, 3'b000);

      // ---- 2: one-cycle request from phase 1 during minimum green ----
      step(1); det = 3'b010;
      step(1); det = 3'b000;
      chk("s2_pend", 3'b110, 3'b000, 3'b001, 2'd0, 3'b010);
      step(9);                                     // G+11
      chk("s2_green_last", 3'b110, 3'b000, 3'b001, 2'd0, 3'b010);
      step(1);                                     // G+12
      chk("s2_amber_first", 3'b110, 3'b001, 3'b000, 2'd0, 3'b010);
      step(7);                                     // G+19
      chk("s2_amber_last", 3'b110, 3'b001, 3'b000, 2'd0, 3'b010);
      step(1);                                     // G+20
      chk("s2_allred", 3'b111, 3'b000, 3'b000, 2'd0, 3'b010);
      step(3);                                     // G+23
      chk("s2_allred_last", 3'b111, 3'b000, 3'b000, 2'd0, 3'b010);

      // ---- 5: det[1] on the grant edge, and while phase 1 is green ----
      det = 3'b010;
      step(1);                                     // H: phase 1 green
      chk("s5_grant_clear", 3'b101, 3'b000, 3'b010, 2'd1, 3'b000);
      step(1);
      chk("s5_green_noset", 3'b101, 3'b000, 3'b010, 2'd1, 3'b000);

      // ---- 4: simultaneous requests from phases 0 and 2 ----
      det = 3'b101;
      step(1); det = 3'b000;                       // H+2
      chk("s4_pend", 3'b101, 3'b000, 3'b010, 2'd1, 3'b101);
      step(10);                                    // H+12
      chk("s4_amber1", 3'b101, 3'b010, 3'b000, 2'd1, 3'b101);
      step(12);                                    // I: phase 2 green
      chk("s4_green2", 3'b011, 3'b000, 3'b100, 2'd2, 3'b001);
      step(12);
      chk("s4_amber2", 3'b011, 3'b100, 3'b000, 2'd2, 3'b001);
      step(12);                                    // J: phase 0 green
      chk("s4_green0", 3'b110, 3'b000, 3'b001, 2'd0, 3'b000);

      // ---- 3: phase 0 held occupied, phase 2 waiting -> GREEN_MAX ----
      det = 3'b101;
      step(1); det = 3'b001;                       // J+1
      chk("s3_pend", 3'b110, 3'b000, 3'b001, 2'd0, 3'b100);
      step(22);                                    // J+23
      chk("s3_green_max_last", 3'b110, 3'b000, 3'b001, 2'd0, 3'b100);
      step(1);                                     // J+24
      chk("s3_amber", 3'b110, 3'b001, 3'b000, 2'd0, 3'b100);
      step(1);                                     // J+25
      chk("s3_amber_reqset", 3'b110, 3'b001, 3'b000, 2'd0, 3'b101);
      det = 3'b000;
      step(11);                                    // K: phase 2 green
      chk("s3_green2", 3'b011, 3'b000, 3'b100, 2'd2, 3'b001);

      // ---- 6: reset in the middle of amber ----
      step(14);                                    // K+14
      chk("s6_mid_amber", 3'b011, 3'b100, 3'b000, 2'd2, 3'b001);
      rstn = 1'b0;
      #1 chk("s6_reset_async", 3'b111, 3'b000, 3'b000, 2'd2, 3'b000);
      step(3);
      rstn = 1'b1;
      step(3);
      chk("s6_allred_end", 3'b111, 3'b000, 3'b000, 2'd2, 3'b000);
      step(1);
      chk("s6_green0", 3'b110, 3'b000, 3'b001, 2'd0, 3'b000);
      step(2);

      n_total++;
      assert (inv_bad === 1'b0) n_pass++;
      else begin
         n_fail++;
         $error("FAIL lamp_invariant: observed violation=%b expected 0", inv_bad);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
